// File: rtl/seqpolar_if.sv
// Request/result bundle for the seqpolar rectangular-to-polar converter.
// The master side issues requests; the slave side (the converter) returns results.
interface seqpolar_if;
    logic               i_stb;
    logic signed [15:0] i_xval;
    logic signed [15:0] i_yval;
    logic               o_busy;
    logic               o_done;
    logic [17:0]        o_mag;
    logic [31:0]        o_phase;

    modport master (
        output i_stb, i_xval, i_yval,
        input  o_busy, o_done, o_mag, o_phase
    );

    modport slave (
        input  i_stb, i_xval, i_yval,
        output o_busy, o_done, o_mag, o_phase
    );
endinterface

// File: rtl/seqpolar.sv
// Sequential CORDIC vectoring engine: one iteration per clock, (x, y) -> (magnitude, phase).
// Define SEQPOLAR_GAIN_COMP_EN to scale out the CORDIC gain (adds one cycle of latency).
module seqpolar (
    input  logic      i_clk,
    input  logic      i_reset,
    seqpolar_if.slave bus
);
    localparam int IW      = 16;
    localparam int WW      = 22;
    localparam int PW      = 32;
    localparam int NSTAGES = 20;
    localparam int MW      = 18;

    localparam logic [PW-1:0] PH_90  = 32'h4000_0000;
    localparam logic [PW-1:0] PH_270 = 32'hC000_0000;
`ifdef SEQPOLAR_GAIN_COMP_EN
    localparam logic [31:0]   GAIN_INV = 32'h9B74_EDA8;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_RUN,
        ST_GAIN,
        ST_OUT
    } state_t;

    // Sign + 2 guard bits above the input, 3 fraction bits below it.
    function automatic logic signed [WW-1:0] expand(input logic signed [IW-1:0] v);
        return {{(WW-IW-3){v[IW-1]}}, v, 3'b000};
    endfunction

    function automatic logic [PW-1:0] angle(input logic [4:0] k);
        case (k)
            5'd0:    return 32'h2000_0000;
            5'd1:    return 32'h12E4_051D;
            5'd2:    return 32'h09FB_385B;
            5'd3:    return 32'h0511_11D4;
            5'd4:    return 32'h028B_0D43;
            5'd5:    return 32'h0145_D7E1;
            5'd6:    return 32'h00A2_F61E;
            5'd7:    return 32'h0051_7C55;
            5'd8:    return 32'h0028_BE53;
            5'd9:    return 32'h0014_5F2E;
            5'd10:   return 32'h000A_2F98;
            5'd11:   return 32'h0005_17CC;
            5'd12:   return 32'h0002_8BE6;
            5'd13:   return 32'h0001_45F3;
            5'd14:   return 32'h0000_A2F9;
            5'd15:   return 32'h0000_517C;
            5'd16:   return 32'h0000_28BE;
            5'd17:   return 32'h0000_145F;
            5'd18:   return 32'h0000_0A2F;
            5'd19:   return 32'h0000_0517;
            default: return '0;
        endcase
    endfunction

    // Round-half-to-even on the 3 fraction bits; saturate rather than wrap.
    function automatic logic [MW-1:0] round_mag(input logic signed [WW-1:0] v);
        logic [WW-4:0] whole;
        logic [WW-4:0] sum;
        logic          up;
        whole = v[WW-1:3];
        up    = v[2] & (v[1] | v[0] | v[3]);
        sum   = whole + {{(WW-4){1'b0}}, up};
        return sum[WW-4] ? '1 : sum[MW-1:0];
    endfunction

    state_t               state_q, state_d;
    logic [4:0]           cnt_q, cnt_d;
    logic signed [WW-1:0] x_q, x_d;
    logic signed [WW-1:0] y_q, y_d;
    logic [PW-1:0]        ph_q, ph_d;
    logic                 zero_q, zero_d;
    logic                 done_q, done_d;
    logic [MW-1:0]        mag_q, mag_d;
    logic [PW-1:0]        phase_q, phase_d;
    logic signed [WW-1:0] x_sh, y_sh;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        ph_d    = ph_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        mag_d   = mag_q;
        phase_d = phase_q;
        x_sh    = x_q >>> cnt_q;
        y_sh    = y_q >>> cnt_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (bus.i_stb) begin
                    x_d     = expand(bus.i_xval);
                    y_d     = expand(bus.i_yval);
                    zero_d  = (bus.i_xval == '0) && (bus.i_yval == '0);
                    state_d = ST_PRE;
                end
            end
            ST_PRE: begin
                if (!x_q[WW-1]) begin
                    ph_d = '0;
                end else if (!y_q[WW-1]) begin
                    x_d  = y_q;
                    y_d  = -x_q;
                    ph_d = PH_90;
                end else begin
                    x_d  = -y_q;
                    y_d  = x_q;
                    ph_d = PH_270;
                end
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // Both updates use the pre-iteration x and y.
                if (!y_q[WW-1]) begin
                    x_d  = x_q + y_sh;
                    y_d  = y_q - x_sh;
                    ph_d = ph_q + angle(cnt_q);
                end else begin
                    x_d  = x_q - y_sh;
                    y_d  = y_q + x_sh;
                    ph_d = ph_q - angle(cnt_q);
                end
                if (cnt_q == 5'(NSTAGES - 1)) begin
                    cnt_d = '0;
`ifdef SEQPOLAR_GAIN_COMP_EN
                    state_d = ST_GAIN;
`else
                    state_d = ST_OUT;
`endif
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
`ifdef SEQPOLAR_GAIN_COMP_EN
            ST_GAIN: begin
                x_d     = WW'(({{PW{1'b0}}, x_q} * {{WW{1'b0}}, GAIN_INV}) >> 32);
                state_d = ST_OUT;
            end
`endif
            ST_OUT: begin
                mag_d   = zero_q ? '0 : round_mag(x_q);
                phase_d = zero_q ? '0 : ph_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            ph_q    <= '0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
            mag_q   <= '0;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ph_q    <= ph_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
            mag_q   <= mag_d;
            phase_q <= phase_d;
        end
    end

    assign bus.o_busy  = (state_q != ST_IDLE);
    assign bus.o_done  = done_q;
    assign bus.o_mag   = mag_q;
    assign bus.o_phase = phase_q;
endmodule
